// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the UART receiver, with level/almost-full,
// sticky overflow and a saturating framing-error counter. Define UART_RX_FIFO_TIMEOUT_EN for the idle timeout.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12
`ifdef UART_RX_FIFO_TIMEOUT_EN
  , parameter int TIMEOUT_CLKS = 64
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  input  logic                     rx_err,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [7:0]               err_count,
  input  logic                     err_clr
`ifdef UART_RX_FIFO_TIMEOUT_EN
  , output logic                   timeout
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] AF   = LW'(AF_THRESH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          err_prev_q, err_prev_d;
  logic          do_read, do_write, err_edge;

  assign rd_valid    = (level_q != '0);
  assign rd_data     = mem_q[rd_ptr_q];
  assign level       = level_q;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;
  assign err_count   = err_count_q;

  // A read in the same cycle frees a slot, so a full FIFO still accepts the byte.
  always_comb begin
    do_read  = rd_valid & rd_ready;
    do_write = rx_done & ((level_q != FULL) | do_read);
    err_edge = rx_err & ~err_prev_q;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (do_write) begin
      mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_read) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_write && !do_read) begin
      level_d = level_q + 1'b1;
    end else if (do_read && !do_write) begin
      level_d = level_q - 1'b1;
    end

    almost_full_d = (level_d >= AF);

    overflow_d = overflow_q;
    if (rx_done && (level_q == FULL) && !do_read) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end

    err_prev_d  = rx_err;
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = err_edge ? 8'd1 : 8'd0;
    end else if (err_edge && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      err_count_q   <= '0;
      err_prev_q    <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      err_count_q   <= err_count_d;
      err_prev_q    <= err_prev_d;
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, COUNT, FIRED} to_state_e;

  to_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Emptying wins over everything; a write always restarts the count from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (level_d == '0) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (do_write) begin
      state_d = COUNT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = COUNT;
          cnt_d   = '0;
        end
        COUNT: begin
          if (cnt_q == 16'(TIMEOUT_CLKS - 1)) begin
            state_d = FIRED;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    timeout = (state_q == FIRED);
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, AF_THRESH=12).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] level;
  logic       almost_full;
  logic       overflow;
  logic       overflow_clr;
  logic [7:0] err_count;
  logic       err_clr;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic       timeout;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH(16),
    .AF_THRESH(12)
`ifdef UART_RX_FIFO_TIMEOUT_EN
    , .TIMEOUT_CLKS(16)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .rx_err(rx_err),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .level(level),
    .almost_full(almost_full),
    .overflow(overflow),
    .overflow_clr(overflow_clr),
    .err_count(err_count),
    .err_clr(err_clr)
`ifdef UART_RX_FIFO_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic done, input logic [7:0] data, input logic ready);
    rx_done  = done;
    rx_data  = data;
    rd_ready = ready;
    tick();
    rx_done  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_data = '0; rx_done = 1'b0; rx_err = 1'b0;
    rd_ready = 1'b0; overflow_clr = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_level", 32'(level), 0);
    checkOutput("rst_valid", 32'(rd_valid), 0);
    checkOutput("rst_data", 32'(rd_data), 0);
    checkOutput("rst_af", 32'(almost_full), 0);
    checkOutput("rst_ovf", 32'(overflow), 0);
    checkOutput("rst_errcnt", 32'(err_count), 0);

    // Two bytes in, then drained in order.
    applyStimulus(1'b1, 8'hA5, 1'b0);
    applyStimulus(1'b1, 8'h3C, 1'b0);
    checkOutput("two_level", 32'(level), 2);
    checkOutput("two_valid", 32'(rd_valid), 1);
    checkOutput("two_head", 32'(rd_data), 32'hA5);
    rd_ready = 1'b1;
    tick();
    checkOutput("two_second", 32'(rd_data), 32'h3C);
    checkOutput("two_level1", 32'(level), 1);
    tick();
    checkOutput("two_empty_level", 32'(level), 0);
    checkOutput("two_empty_valid", 32'(rd_valid), 0);
    rd_ready = 1'b0;

    // Seventeen bytes into a 16-deep FIFO: the last one is dropped.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      if (i == 10) checkOutput("af_at_11", 32'(almost_full), 0);
      if (i == 11) checkOutput("af_at_12", 32'(almost_full), 1);
      if (i == 15) checkOutput("ovf_before", 32'(overflow), 0);
    end
    checkOutput("full_level", 32'(level), 16);
    checkOutput("full_ovf", 32'(overflow), 1);
    checkOutput("full_af", 32'(almost_full), 1);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("drain_%0d", i), 32'(rd_data), 32'(i));
      tick();
    end
    rd_ready = 1'b0;
    checkOutput("drain_level", 32'(level), 0);
    checkOutput("drain_valid", 32'(rd_valid), 0);
    checkOutput("ovf_sticky", 32'(overflow), 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    checkOutput("ovf_clr", 32'(overflow), 0);

    // Full FIFO with a simultaneous read and write.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'h20 + 8'(i), 1'b0);
    end
    applyStimulus(1'b1, 8'h99, 1'b1);
    checkOutput("rw_full_level", 32'(level), 16);
    checkOutput("rw_full_ovf", 32'(overflow), 0);
    overflow_clr = 1'b1;
    applyStimulus(1'b1, 8'hEE, 1'b0);
    overflow_clr = 1'b0;
    checkOutput("ovf_set_beats_clr", 32'(overflow), 1);
    checkOutput("ovf_set_level", 32'(level), 16);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    checkOutput("ovf_clr2", 32'(overflow), 0);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("rw_drain_%0d", i), 32'(rd_data), (i < 15) ? 32'h21 + 32'(i) : 32'h99);
      tick();
    end
    rd_ready = 1'b0;
    checkOutput("rw_drain_level", 32'(level), 0);

    // Framing-error edges: count, saturate, clear.
    for (int i = 0; i < 3; i++) begin
      rx_err = 1'b1;
      repeat (5) tick();
      rx_err = 1'b0;
      tick();
    end
    checkOutput("err_three", 32'(err_count), 3);
    for (int i = 0; i < 300; i++) begin
      rx_err = 1'b1;
      tick();
      rx_err = 1'b0;
      tick();
    end
    checkOutput("err_sat", 32'(err_count), 255);
    rx_err = 1'b1;
    err_clr = 1'b1;
    tick();
    checkOutput("err_clr_edge", 32'(err_count), 1);
    tick();
    err_clr = 1'b0;
    checkOutput("err_clr_only", 32'(err_count), 0);
    rx_err = 1'b0;
    tick();
    rx_err = 1'b1;
    tick();
    rx_err = 1'b0;
    checkOutput("err_one", 32'(err_count), 1);

    // Reset in mid-stream, with an rx_done in the reset cycle that must be ignored.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h50 + 8'(i), 1'b0);
    end
    checkOutput("mid_level5", 32'(level), 5);
    rst = 1'b1;
    applyStimulus(1'b1, 8'hCC, 1'b0);
    rst = 1'b0;
    checkOutput("mid_rst_level", 32'(level), 0);
    checkOutput("mid_rst_valid", 32'(rd_valid), 0);
    checkOutput("mid_rst_ovf", 32'(overflow), 0);
    checkOutput("mid_rst_err", 32'(err_count), 0);
    applyStimulus(1'b1, 8'h77, 1'b0);
    checkOutput("post_rst_data", 32'(rd_data), 32'h77);
    checkOutput("post_rst_level", 32'(level), 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    rd_ready = 1'b0;
    checkOutput("post_rst_empty", 32'(level), 0);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    // One byte then idle: timeout rises 16 cycles after the write edge.
    applyStimulus(1'b1, 8'h42, 1'b0);
    checkOutput("to_after_write", 32'(timeout), 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) checkOutput("to_at_15", 32'(timeout), 0);
      if (k == 16) checkOutput("to_at_16", 32'(timeout), 1);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    rd_ready = 1'b0;
    checkOutput("to_after_read", 32'(timeout), 0);
    checkOutput("to_level", 32'(level), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
